i2s_transmit: RTL and testbench
===============================

Name: i2s_transmit

Overview:
- I2S master transmitter: the output side of the synth's audio path.
- Takes stereo PCM samples from the voice mixer through a valid/ready handshake.
- Generates sck and ws from the system clock and serialises both channels MSB-first onto sd.
- Output is in standard I2S format: ws leads data by one sck, and the block is directly compatible with the team's I2S receiver.

Parameters:
- WIDTH, 32, bits per channel slot; frame = 2*WIDTH sck periods; must be >= 2.
- CLK_DIV, 4, clk cycles per sck half-period; must be >= 1.

Ports:
- clk  input  1  system clock; all logic on posedge clk.
- rst_n  input  1  asynchronous active-low reset.
- data_left  input  WIDTH  left sample, two's complement, sent MSB first.
- data_right  input  WIDTH  right sample, two's complement, sent MSB first.
- sample_valid  input  1  data_left and data_right are valid.
- sample_ready  output  1  holding register is empty; a sample is accepted when valid && ready.
- sck  output  1  I2S bit clock, registered.
- ws  output  1  word select: 0 = left, 1 = right; registered.
- sd  output  1  serial data, registered.
- frame_start  output  1  one-clk pulse when a frame is loaded into the shifter.
- underrun  output  1  one-clk pulse when a frame loads while the holding register is empty.

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: sck=0, ws=0, sd=0, sample_ready=1, frame_start=0, underrun=0.
  - Internal: divider=0, bit index b=0, holding register empty, shifter=0.
- Divider:
  - Counts 0..CLK_DIV-1 on clk.
  - On terminal count it wraps to 0 and sck toggles.
  - sck period = 2*CLK_DIV clk cycles, duty 50%.
- Falling event = the clk cycle in which sck is toggled 1->0. All of the following update in that same cycle, so sd and ws change together with the sck falling edge and stay stable across the rising edge:
  - b
  - sd
  - ws
  - shifter
  - holding-register state
- The first falling event after reset outputs b=0.
- Frame bit order: b = 0..2*WIDTH-1.
  - b=0..WIDTH-1 carry the left sample, MSB first.
  - b=WIDTH..2*WIDTH-1 carry the right sample, MSB first.
  - At each falling event, sd = frame bit b; then b increments, wrapping 2*WIDTH-1 -> 0.
- ws (one-bit lead):
  - ws is set to 1 at the falling event that outputs b=WIDTH-1 (left LSB).
  - ws is set to 0 at the falling event that outputs b=2*WIDTH-1 (right LSB).
  - ws is otherwise unchanged.
- Frame load, at the falling event with b=0:
  - If the holding register is full: the shifter loads {left,right}, the holding register becomes empty, and frame_start pulses.
  - If it is empty: the shifter loads all zeros, and frame_start and underrun both pulse.
  - sd for b=0 is the MSB of the loaded value in that same cycle.
- Holding register:
  - A handshake (valid && ready) captures both samples; ready drops the next cycle.
  - A handshake in the same cycle as a frame load fills the holding register for the next frame. The load uses the pre-handshake content: if empty, an underrun is reported and the new sample is kept, not lost.
  - ready rises the cycle after a load that emptied the holding register.
  - Inputs are ignored while ready=0.
- Latency: a sample accepted during frame N is transmitted in frame N+1, or in the first frame when accepted before the first b=0 event.
- Throughput: one sample per 4*WIDTH*CLK_DIV clk cycles.
- Reset mid-frame: sck, ws and sd drop to 0 immediately; any pending sample is discarded; after release, operation restarts at b=0.
- The receiver misses the first left word after reset because there is no ws edge before it; this is accepted.

Test Plan:
- WIDTH=8, CLK_DIV=2, sample 0xA5/0x3C presented before the first falling event:
  - sd sequence over b=0..15 is 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0.
  - ws rises at the edge outputting b=7 and falls at the edge outputting b=15.
  - sck period is 4 clk.
- Back-to-back with sample_valid held high and values 0x01/0x02, 0x03/0x04, ...:
  - Exactly one handshake per 64 clk.
  - Frames carry consecutive samples in order, with no underrun.
- No samples supplied:
  - sd stays 0.
  - frame_start and underrun pulse together every 64 clk.
  - ws still toggles.
- Handshake in the same cycle as the b=0 load with the holding register empty:
  - underrun pulses and that frame is zeros.
  - The next frame carries the new sample.
- Assert rst_n low mid-right-channel:
  - sck, ws and sd go 0 asynchronously and sample_ready=1.
  - After release, the first falling event occurs after 2*CLK_DIV clk and outputs b=0.
- Loopback into the team's I2S receiver with WIDTH=8: from the second frame onward, data_left and data_right match the transmitted samples.

Source files
------------

// File: rtl/i2s_transmit.sv
// I2S master transmitter: divides clk into sck/ws and shifts stereo
// PCM frames MSB-first onto sd, fed through a one-deep holding register.
module i2s_transmit #(
  parameter int WIDTH   = 32,
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_left,
  input  logic [WIDTH-1:0] data_right,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic             sck,
  output logic             ws,
  output logic             sd,
  output logic             frame_start,
  output logic             underrun
);

  localparam int FW = 2 * WIDTH;
  localparam int BW = $clog2(FW);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_TC = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] B_LLSB = BW'(WIDTH - 1);
  localparam logic [BW-1:0] B_RLSB = BW'(FW - 1);

  logic [DW-1:0] div_q, div_d;
  logic [BW-1:0] b_q, b_d;
  logic [FW-1:0] shift_q, shift_d;
  logic [FW-1:0] hold_q, hold_d;
  logic          full_q, full_d;
  logic          sck_q, sck_d;
  logic          ws_q, ws_d;
  logic          sd_q, sd_d;
  logic          fs_q, fs_d;
  logic          ur_q, ur_d;

  logic          tc;
  logic          fall;
  logic          hs;
  logic [FW-1:0] load;

  // Divider, bit sequencing, frame load and holding-register handshake
  always_comb begin
    div_d   = div_q;
    b_d     = b_q;
    shift_d = shift_q;
    hold_d  = hold_q;
    full_d  = full_q;
    sck_d   = sck_q;
    ws_d    = ws_q;
    sd_d    = sd_q;
    fs_d    = 1'b0;
    ur_d    = 1'b0;

    tc   = (div_q == DIV_TC);
    fall = tc & sck_q;
    hs   = sample_valid & ~full_q;
    load = full_q ? hold_q : '0;

    if (tc) begin
      div_d = '0;
      sck_d = ~sck_q;
    end else begin
      div_d = div_q + 1'b1;
    end

    if (fall) begin
      if (b_q == '0) begin
        sd_d    = load[FW-1];
        shift_d = {load[FW-2:0], 1'b0};
        full_d  = 1'b0;
        fs_d    = 1'b1;
        ur_d    = ~full_q;
      end else begin
        sd_d    = shift_q[FW-1];
        shift_d = {shift_q[FW-2:0], 1'b0};
      end

      if (b_q == B_LLSB) begin
        ws_d = 1'b1;
      end else if (b_q == B_RLSB) begin
        ws_d = 1'b0;
      end

      b_d = (b_q == B_RLSB) ? '0 : b_q + 1'b1;
    end

    // Pre-handshake content was used by the load above, so a sample
    // arriving on the load cycle waits for the next frame.
    if (hs) begin
      full_d = 1'b1;
      hold_d = {data_left, data_right};
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      b_q     <= '0;
      shift_q <= '0;
      hold_q  <= '0;
      full_q  <= 1'b0;
      sck_q   <= 1'b0;
      ws_q    <= 1'b0;
      sd_q    <= 1'b0;
      fs_q    <= 1'b0;
      ur_q    <= 1'b0;
    end else begin
      div_q   <= div_d;
      b_q     <= b_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      full_q  <= full_d;
      sck_q   <= sck_d;
      ws_q    <= ws_d;
      sd_q    <= sd_d;
      fs_q    <= fs_d;
      ur_q    <= ur_d;
    end
  end

  assign sample_ready = ~full_q;
  assign sck          = sck_q;
  assign ws           = ws_q;
  assign sd           = sd_q;
  assign frame_start  = fs_q;
  assign underrun     = ur_q;

endmodule

// File: tb/tb_i2s_transmit.sv
// Bench for i2s_transmit: cycle-numbered reference model of the I2S
// frame timing plus directed and random stimulus.
module tb_i2s_transmit;

  localparam int W   = 8;
  localparam int CD  = 2;
  localparam int FW  = 2 * W;
  localparam int PER = 2 * CD;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] dl = '0;
  logic [W-1:0] dr = '0;
  logic         v = 1'b0;
  logic         sample_ready;
  logic         sck;
  logic         ws;
  logic         sd;
  logic         frame_start;
  logic         underrun;

  i2s_transmit #(.WIDTH(W), .CLK_DIV(CD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_left    (dl),
    .data_right   (dr),
    .sample_valid (v),
    .sample_ready (sample_ready),
    .sck          (sck),
    .ws           (ws),
    .sd           (sd),
    .frame_start  (frame_start),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model: n = clk edges since reset release
  int          n;
  int          m_b;
  bit          m_full, m_hs, m_fall;
  bit          m_sd, m_ws, m_fs, m_ur, m_sck;
  logic [W-1:0]  m_l, m_r;
  logic [FW-1:0] m_frame;

  logic [FW-1:0] cap, last_frame;
  int fs_cnt, ur_cnt, hs_cnt, frames;

  task automatic model_reset();
    n = 0; m_b = 0;
    m_full = 0; m_hs = 0; m_fall = 0;
    m_sd = 0; m_ws = 0; m_fs = 0; m_ur = 0; m_sck = 0;
    m_l = '0; m_r = '0; m_frame = '0;
    cap = '0; last_frame = '0;
    fs_cnt = 0; ur_cnt = 0; hs_cnt = 0; frames = 0;
  endtask

  task automatic step();
    if (v && sample_ready) hs_cnt++;
    @(posedge clk);
    n++;
    m_fs = 0; m_ur = 0; m_fall = 0;
    m_hs = v && !m_full;
    if (n % PER == 0) begin
      m_fall = 1;
      m_b = (n / PER - 1) % FW;
      if (m_b == 0) begin
        m_fs = 1;
        if (m_full) begin
          m_frame = {m_l, m_r};
          m_full = 0;
        end else begin
          m_frame = '0;
          m_ur = 1;
        end
      end
      m_sd = m_frame[FW-1-m_b];
      m_ws = (m_b >= W - 1) && (m_b <= FW - 2);
    end
    if (m_hs) begin
      m_full = 1; m_l = dl; m_r = dr;
    end
    m_sck = ((n / CD) % 2) == 1;
    @(negedge clk);
    check($sformatf("outs n=%0d", n),
          {26'b0, sck, ws, sd, sample_ready, frame_start, underrun},
          {26'b0, m_sck, m_ws, m_sd, !m_full, m_fs, m_ur});
    if (frame_start) fs_cnt++;
    if (underrun) ur_cnt++;
    if (m_fall) begin
      cap[FW-1-m_b] = sd;
      if (m_b == FW - 1) begin
        last_frame = cap;
        frames++;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    v = 1'b0;
    #2;
    check("reset outs",
          {26'b0, sck, ws, sd, sample_ready, frame_start, underrun},
          32'b000100);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic mid_reset();
    #1 rst_n = 1'b0;
    #1;
    check("async reset outs",
          {26'b0, sck, ws, sd, sample_ready, frame_start, underrun},
          32'b000100);
    v = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  int idx;

  initial begin
    model_reset();
    #12;
    do_reset();

    // Single sample presented before the first falling event
    v = 1'b1; dl = 8'hA5; dr = 8'h3C;
    repeat (64) begin
      step();
      if (m_hs) v = 1'b0;
    end
    check("frame A5/3C", 32'(last_frame), 32'hA53C);
    repeat (64) step();
    check("second frame zero", 32'(last_frame), 32'h0);
    check("one underrun", 32'(ur_cnt), 32'd1);

    // Back-to-back samples
    do_reset();
    idx = 0;
    v = 1'b1; dl = 8'h01; dr = 8'h02;
    repeat (324) begin
      step();
      if (m_hs) begin
        idx++;
        dl = 8'(2 * idx + 1);
        dr = 8'(2 * idx + 2);
      end
    end
    check("b2b handshakes", 32'(hs_cnt), 32'd6);
    check("b2b underruns", 32'(ur_cnt), 32'd0);
    check("b2b frame5", 32'(last_frame), 32'h090A);
    v = 1'b0;

    // No samples at all
    do_reset();
    repeat (200) step();
    check("idle frame_start", 32'(fs_cnt), 32'd4);
    check("idle underrun", 32'(ur_cnt), 32'd4);
    check("idle frame", 32'(last_frame), 32'h0);

    // Handshake on the very cycle of an empty load
    do_reset();
    while (n < 67) step();
    v = 1'b1; dl = 8'h5A; dr = 8'hC3;
    step();
    v = 1'b0;
    while (n < 128) step();
    check("load-cycle frame zero", 32'(last_frame), 32'h0);
    while (n < 192) step();
    check("load-cycle next frame", 32'(last_frame), 32'h5AC3);
    check("load-cycle underruns", 32'(ur_cnt), 32'd2);

    // Random traffic with a reset during the right channel
    do_reset();
    repeat (50) begin
      v  = ($urandom_range(0, 3) == 0);
      dl = 8'($urandom);
      dr = 8'($urandom);
      step();
    end
    mid_reset();
    repeat (260) begin
      v  = ($urandom_range(0, 5) == 0);
      dl = 8'($urandom);
      dr = 8'($urandom);
      step();
    end
    v = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
